// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 sizes, writeback select,
// FSM states, byte-lane size masks and the alignment check.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsu_state_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  // A doubleword request on a 32-bit datapath is treated as a full word.
  function automatic logic [7:0] size_mask(input logic [1:0] size, input logic is64);
    case (size)
      2'b00:   return MASK_B;
      2'b01:   return MASK_H;
      2'b10:   return MASK_W;
      default: return is64 ? MASK_D : MASK_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off,
                                         input logic is64);
    logic [2:0] amask;
    case (size)
      2'b00:   amask = 3'd0;
      2'b01:   amask = 3'd1;
      2'b10:   amask = 3'd3;
      default: amask = is64 ? 3'd7 : 3'd3;
    endcase
    return |(off & amask);
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational store lane/byte-enable generation and load extract/extend.
// Misaligned lanes are simply truncated here; trapping (RISCV_DMEM_MISALIGN_TRAP_EN) lives in the top.
module riscv_lsu_align #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned NB = XLEN / 8,
  localparam int unsigned OW = $clog2(NB)
) (
  input  logic [2:0]      i_funct3,
  input  logic [OW-1:0]   i_off,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_wdata,
  output logic [NB-1:0]   o_byte_sel,
  output logic [XLEN-1:0] o_rdata
);
  import riscv_mem_pkg::*;

  localparam logic IS64 = (XLEN == 64);

  logic [7:0]      w_mask;
  logic [XLEN-1:0] w_sh;

  assign w_mask     = size_mask(i_funct3[1:0], IS64);
  assign o_byte_sel = NB'(w_mask) << i_off;
  assign o_wdata    = i_wdata << {i_off, 3'b000};
  assign w_sh       = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_rdata = '0;
    case (i_funct3)
      F3_B:    o_rdata = XLEN'($signed(w_sh[7:0]));
      F3_H:    o_rdata = XLEN'($signed(w_sh[15:0]));
      F3_W:    o_rdata = XLEN'($signed(w_sh[31:0]));
      F3_D:    o_rdata = w_sh;
      F3_BU:   o_rdata = XLEN'(w_sh[7:0]);
      F3_HU:   o_rdata = XLEN'(w_sh[15:0]);
      F3_WU:   o_rdata = XLEN'(w_sh[31:0]);
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/riscv_memory_lsu.sv
// MEM stage: EX/MEM register plus valid/ready data-memory access FSM.
// Define RISCV_DMEM_MISALIGN_TRAP_EN to suppress and flag misaligned accesses.
module riscv_memory_lsu #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned NB = XLEN / 8,
  localparam int unsigned OW = $clog2(NB)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_validE,
  input  logic            i_ctrl_reg_wr_enE,
  input  logic [1:0]      i_ctrl_result_srcE,
  input  logic            i_ctrl_mem_wr_enE,
  input  logic            i_ctrl_mem_rd_enE,
  input  logic [2:0]      i_ctrl_mem_funct3E,
  input  logic [XLEN-1:0] i_alu_resultE,
  input  logic [XLEN-1:0] i_mem_writedataE,
  input  logic [4:0]      i_regfile_rd_addrE,
  input  logic [XLEN-1:0] i_PCPlus4E,
  output logic            o_dmem_req_valid,
  input  logic            i_dmem_req_ready,
  output logic            o_dmem_wr_en,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [NB-1:0]   o_dmem_byte_sel,
  input  logic            i_dmem_rsp_valid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_stallM,
  output logic            o_validM,
  output logic            o_ctrl_reg_wr_enM,
  output logic [1:0]      o_ctrl_result_srcM,
  output logic [4:0]      o_regfile_rd_addrM,
  output logic [XLEN-1:0] o_alu_resultM,
  output logic [XLEN-1:0] o_PCPlus4M,
  output logic [XLEN-1:0] o_mem_readdataM,
  output logic            o_misalignM
);
  import riscv_mem_pkg::*;

  lsu_state_e      r_state, w_state_nxt;
  logic            r_valid, r_reg_wr_en, r_mem_wr, r_misalign;
  logic [1:0]      r_result_src;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_alu, r_wdata, r_pc4, r_readdata;

  logic            w_stall, w_req, w_memopE, w_misalignE;
  logic [XLEN-1:0] w_st_wdata, w_ld_data;
  logic [NB-1:0]   w_byte_sel;

  assign w_stall  = (r_state == StReq) || (r_state == StWait);
  assign w_req    = (r_state == StReq);
  assign w_memopE = i_validE & (i_ctrl_mem_wr_enE | i_ctrl_mem_rd_enE);

`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
  assign w_misalignE = w_memopE & is_misaligned(i_ctrl_mem_funct3E[1:0],
                                                3'(i_alu_resultE[OW-1:0]), XLEN == 64);
`else
  assign w_misalignE = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StReq:  if (i_dmem_req_ready) w_state_nxt = r_mem_wr ? StDone : StWait;
      StWait: if (i_dmem_rsp_valid) w_state_nxt = StDone;
      // Idle/Done: the M register captures this cycle.
      default: begin
        if (!w_memopE)       w_state_nxt = StIdle;
        else if (w_misalignE) w_state_nxt = StDone;
        else                  w_state_nxt = StReq;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid      <= 1'b0;
      r_reg_wr_en  <= 1'b0;
      r_result_src <= '0;
      r_mem_wr     <= 1'b0;
      r_misalign   <= 1'b0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_alu        <= '0;
      r_wdata      <= '0;
      r_pc4        <= '0;
      r_readdata   <= '0;
    end else begin
      if (!w_stall) begin
        r_valid      <= i_validE;
        r_reg_wr_en  <= i_ctrl_reg_wr_enE & ~w_misalignE;
        r_result_src <= i_ctrl_result_srcE;
        r_mem_wr     <= i_validE & i_ctrl_mem_wr_enE;
        r_misalign   <= w_misalignE;
        r_funct3     <= i_ctrl_mem_funct3E;
        r_rd         <= i_regfile_rd_addrE;
        r_alu        <= i_alu_resultE;
        r_wdata      <= i_mem_writedataE;
        r_pc4        <= i_PCPlus4E;
      end
      if ((r_state == StWait) && i_dmem_rsp_valid) r_readdata <= w_ld_data;
    end
  end

  riscv_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .i_funct3  (r_funct3),
    .i_off     (r_alu[OW-1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (i_dmem_rdata),
    .o_wdata   (w_st_wdata),
    .o_byte_sel(w_byte_sel),
    .o_rdata   (w_ld_data)
  );

  assign o_dmem_req_valid   = w_req;
  assign o_dmem_wr_en       = w_req & r_mem_wr;
  assign o_dmem_addr        = {r_alu[XLEN-1:OW], {OW{1'b0}}};
  assign o_dmem_wdata       = w_st_wdata;
  assign o_dmem_byte_sel    = w_req ? w_byte_sel : '0;
  assign o_stallM           = w_stall;
  assign o_validM           = r_valid & ~w_stall;
  assign o_ctrl_reg_wr_enM  = r_reg_wr_en;
  assign o_ctrl_result_srcM = r_result_src;
  assign o_regfile_rd_addrM = r_rd;
  assign o_alu_resultM      = r_alu;
  assign o_PCPlus4M         = r_pc4;
  assign o_mem_readdataM    = r_readdata;
  assign o_misalignM        = r_misalign;

endmodule

// File: tb/tb_riscv_memory_lsu.sv
// Directed self-checking bench for riscv_memory_lsu (XLEN=32).
module tb_riscv_memory_lsu;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_e, reg_wr_e, mem_wr_e, mem_rd_e;
  logic [1:0]  res_src_e;
  logic [2:0]  f3_e;
  logic [31:0] alu_e, wd_e, pc4_e;
  logic [4:0]  rd_e;
  logic        req_valid, req_ready, dmem_wr, rsp_valid;
  logic [31:0] dmem_addr, dmem_wdata, rdata;
  logic [3:0]  byte_sel;
  logic        stall, valid_m, reg_wr_m, misalign_m;
  logic [1:0]  res_src_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_m, pc4_m, readdata_m;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  riscv_memory_lsu #(
    .XLEN(32)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_validE          (valid_e),
    .i_ctrl_reg_wr_enE (reg_wr_e),
    .i_ctrl_result_srcE(res_src_e),
    .i_ctrl_mem_wr_enE (mem_wr_e),
    .i_ctrl_mem_rd_enE (mem_rd_e),
    .i_ctrl_mem_funct3E(f3_e),
    .i_alu_resultE     (alu_e),
    .i_mem_writedataE  (wd_e),
    .i_regfile_rd_addrE(rd_e),
    .i_PCPlus4E        (pc4_e),
    .o_dmem_req_valid  (req_valid),
    .i_dmem_req_ready  (req_ready),
    .o_dmem_wr_en      (dmem_wr),
    .o_dmem_addr       (dmem_addr),
    .o_dmem_wdata      (dmem_wdata),
    .o_dmem_byte_sel   (byte_sel),
    .i_dmem_rsp_valid  (rsp_valid),
    .i_dmem_rdata      (rdata),
    .o_stallM          (stall),
    .o_validM          (valid_m),
    .o_ctrl_reg_wr_enM (reg_wr_m),
    .o_ctrl_result_srcM(res_src_m),
    .o_regfile_rd_addrM(rd_m),
    .o_alu_resultM     (alu_m),
    .o_PCPlus4M        (pc4_m),
    .o_mem_readdataM   (readdata_m),
    .o_misalignM       (misalign_m)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic st,
                       input logic ld, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd);
    valid_e = v; reg_wr_e = rw; res_src_e = rs; mem_wr_e = st; mem_rd_e = ld;
    f3_e = f3; alu_e = alu; wd_e = wd; rd_e = rd; pc4_e = 32'h0000_1004;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, RES_ALU, 1'b0, 1'b0, F3_B, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp);
    req_ready = 1'b1;
    drive(1'b1, 1'b1, RES_MEM, 1'b0, 1'b1, f3, addr, 32'h0, 5'd7);
    tick();
    check_eq({tag, "_stall"}, stall, 1);
    bubble();
    tick();
    rsp_valid = 1'b1;
    rdata     = data;
    tick();
    rsp_valid = 1'b0;
    check_eq({tag, "_data"}, readdata_m, exp);
    check_eq({tag, "_validM"}, valid_m, 1);
    tick();
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] sel, input logic [31:0] wd);
    req_ready = 1'b1;
    drive(1'b1, 1'b0, RES_ALU, 1'b1, 1'b0, f3, addr, data, 5'd0);
    tick();
    check_eq({tag, "_sel"}, byte_sel, sel);
    check_eq({tag, "_wdata"}, dmem_wdata, wd);
    check_eq({tag, "_wr"}, dmem_wr, 1);
    bubble();
    tick();
    check_eq({tag, "_done_stall"}, stall, 0);
    tick();
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rdata = 32'h0;
    bubble();
    tick();
    tick();
    check_eq("rst_stall", stall, 0);
    check_eq("rst_validM", valid_m, 0);
    check_eq("rst_req", req_valid, 0);
    check_eq("rst_sel", byte_sel, 0);
    check_eq("rst_rdata", readdata_m, 0);
    check_eq("rst_alu", alu_m, 0);
    rst = 1'b0;

    // 1: LW with immediate accept and one-cycle response
    drive(1'b1, 1'b1, RES_MEM, 1'b0, 1'b1, F3_W, 32'h0000_0100, 32'h0, 5'd3);
    tick();
    check_eq("lw_stall1", stall, 1);
    check_eq("lw_req", req_valid, 1);
    check_eq("lw_addr", dmem_addr, 32'h100);
    check_eq("lw_wr", dmem_wr, 0);
    check_eq("lw_valid_stall", valid_m, 0);
    bubble();
    tick();
    check_eq("lw_stall2", stall, 1);
    check_eq("lw_req_wait", req_valid, 0);
    rsp_valid = 1'b1;
    rdata     = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    check_eq("lw_stall_done", stall, 0);
    check_eq("lw_data", readdata_m, 32'hDEAD_BEEF);
    check_eq("lw_validM", valid_m, 1);
    check_eq("lw_rd", rd_m, 3);
    tick();

    // 2: sub-word loads and extension
    do_load("lb", F3_B, 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
    do_load("lbu", F3_BU, 32'h103, 32'h8011_2233, 32'h0000_0080);
    do_load("lhu", F3_HU, 32'h102, 32'h8011_2233, 32'h0000_8011);
    do_load("lh", F3_H, 32'h102, 32'h8011_2233, 32'hFFFF_8011);
    do_load("lb0", F3_B, 32'h100, 32'h8011_2233, 32'h0000_0033);
    do_load("rsvd", 3'b111, 32'h100, 32'h8011_2233, 32'h0);

    // 3: SH with ready held low for three cycles
    req_ready = 1'b0;
    drive(1'b1, 1'b0, RES_ALU, 1'b1, 1'b0, F3_H, 32'h102, 32'h0000_ABCD, 5'd0);
    tick();
    bubble();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("sh_stall%0d", i), stall, 1);
      check_eq($sformatf("sh_sel%0d", i), byte_sel, 4'b1100);
      check_eq($sformatf("sh_wdata%0d", i), dmem_wdata, 32'hABCD_0000);
      check_eq($sformatf("sh_addr%0d", i), dmem_addr, 32'h100);
      check_eq($sformatf("sh_wr%0d", i), dmem_wr, 1);
      tick();
    end
    req_ready = 1'b1;
    check_eq("sh_stall3", stall, 1);
    check_eq("sh_req3", req_valid, 1);
    tick();
    check_eq("sh_done_stall", stall, 0);
    check_eq("sh_done_req", req_valid, 0);
    check_eq("sh_validM", valid_m, 1);
    tick();

    do_store("sb", F3_B, 32'h101, 32'h0000_00AB, 4'b0010, 32'h0000_AB00);
    do_store("sw", F3_W, 32'h104, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    // 4: ALU, bubble, ALU
    drive(1'b1, 1'b1, RES_PC4, 1'b0, 1'b0, F3_B, 32'h11, 32'h0, 5'd9);
    tick();
    check_eq("alu1_valid", valid_m, 1);
    check_eq("alu1_res", alu_m, 32'h11);
    check_eq("alu1_src", res_src_m, RES_PC4);
    check_eq("alu1_pc4", pc4_m, 32'h1004);
    check_eq("alu1_rd", rd_m, 9);
    check_eq("alu1_req", req_valid, 0);
    drive(1'b0, 1'b1, RES_ALU, 1'b0, 1'b0, F3_B, 32'h22, 32'h0, 5'd0);
    check_eq("alu_delay", alu_m, 32'h11);
    tick();
    check_eq("bub_valid", valid_m, 0);
    check_eq("bub_stall", stall, 0);
    drive(1'b1, 1'b1, RES_ALU, 1'b0, 1'b0, F3_B, 32'h33, 32'h0, 5'd1);
    tick();
    check_eq("alu2_valid", valid_m, 1);
    check_eq("alu2_res", alu_m, 32'h33);
    check_eq("alu2_stall", stall, 0);
    bubble();
    tick();

    // 5: reset during WAIT, late response ignored
    drive(1'b1, 1'b1, RES_MEM, 1'b0, 1'b1, F3_W, 32'h100, 32'h0, 5'd4);
    tick();
    bubble();
    tick();
    check_eq("rw_wait_stall", stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_valid = 1'b1;
    rdata     = 32'h1234_5678;
    tick();
    rsp_valid = 1'b0;
    check_eq("rw_stall", stall, 0);
    check_eq("rw_validM", valid_m, 0);
    check_eq("rw_rdata", readdata_m, 0);
    check_eq("rw_req", req_valid, 0);
    check_eq("rw_alu", alu_m, 0);
    tick();

    // 6: misaligned LW at 0x102
    req_ready = 1'b1;
    drive(1'b1, 1'b1, RES_MEM, 1'b0, 1'b1, F3_W, 32'h102, 32'h0, 5'd5);
    tick();
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
    check_eq("mis_req", req_valid, 0);
    check_eq("mis_flag", misalign_m, 1);
    check_eq("mis_regwr", reg_wr_m, 0);
    check_eq("mis_stall", stall, 0);
    bubble();
    tick();
`else
    check_eq("mis_req", req_valid, 1);
    check_eq("mis_flag", misalign_m, 0);
    check_eq("mis_sel", byte_sel, 4'b1100);
    check_eq("mis_regwr", reg_wr_m, 1);
    bubble();
    tick();
    rsp_valid = 1'b1;
    rdata     = 32'h1122_3344;
    tick();
    rsp_valid = 1'b0;
    check_eq("mis_data", readdata_m, 32'h0000_1122);
`endif
    tick();
    check_eq("end_flag", misalign_m, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_memory_lsu.md
Name: riscv_memory_lsu

Overview:
Parametrised MEM stage for the pipelined core. It holds the EX/MEM pipeline register and drives the data memory over a valid/ready request channel and a valid response channel, so memory may take any number of cycles. It builds store byte lanes and data, and aligns and sign/zero-extends load data. It raises a stall to the hazard unit while an access is outstanding, and feeds the writeback stage.

Parameters:
XLEN, 32, datapath width; 32 or 64.
NB, XLEN/8, byte lanes (localparam).
OW, log2(NB), byte-offset bits (localparam).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_validE  in  1  EX slot holds a real instruction
i_ctrl_reg_wr_enE  in  1  register write enable
i_ctrl_result_srcE  in  2  writeback mux select
i_ctrl_mem_wr_enE  in  1  store
i_ctrl_mem_rd_enE  in  1  load
i_ctrl_mem_funct3E  in  3  access size and signedness (RV funct3)
i_alu_resultE  in  XLEN  address or ALU result
i_mem_writedataE  in  XLEN  store data
i_regfile_rd_addrE  in  5  destination register
i_PCPlus4E  in  XLEN  PC+4
o_dmem_req_valid  out  1  request valid
i_dmem_req_ready  in  1  request accepted
o_dmem_wr_en  out  1  request is a write
o_dmem_addr  out  XLEN  aligned address (low OW bits zero)
o_dmem_wdata  out  XLEN  lane-shifted store data
o_dmem_byte_sel  out  NB  byte enables
i_dmem_rsp_valid  in  1  read data valid
i_dmem_rdata  in  XLEN  read data
o_stallM  out  1  hold EX and earlier stages
o_validM  out  1  M result complete and valid for W
o_ctrl_reg_wr_enM  out  1  registered control
o_ctrl_result_srcM  out  2  registered control
o_regfile_rd_addrM  out  5  registered destination register
o_alu_resultM  out  XLEN  registered ALU result
o_PCPlus4M  out  XLEN  registered PC+4
o_mem_readdataM  out  XLEN  aligned and extended load data
o_misalignM  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset: all M registers and outputs are 0, the FSM is IDLE, and o_stallM is 0.
- Capture: on each rising edge with o_stallM=0, the E inputs load into the M register.
  - If i_validE=0, a bubble is captured: valid_q=0 and no request is issued.
  - If a memory op is captured, the FSM goes to REQ; otherwise it goes to IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
  - REQ: o_dmem_req_valid=1. Address, wdata, byte_sel and wr_en are held stable until handshake (req_valid & req_ready). On handshake, a store goes to DONE and a load goes to WAIT.
  - WAIT: on i_dmem_rsp_valid, the aligned/extended data registers into o_mem_readdataM and the FSM goes to DONE.
  - The response may arrive no earlier than the cycle after acceptance. A response in any state other than WAIT is ignored.
  - DONE, IDLE: no request is issued.
- o_stallM = (state==REQ) | (state==WAIT), combinational.
- o_validM = valid_q & ~o_stallM.
- Latency:
  - Non-memory op: 1 cycle, no stall.
  - Store with ready=1: 1 stall cycle.
  - Load with ready=1 and a 1-cycle response: 2 stall cycles.
- Store lanes: off = alu[OW-1:0]; o_dmem_byte_sel = sizemask << off; o_dmem_wdata = writedata << 8*off.
  - sizemask is 1, 3 or 0xF for B/H/W, and 0xFF for D when XLEN=64.
  - Bits shifted past NB are dropped.
- Loads: rdata >> 8*off, then extend according to funct3:
  - 000 LB and 001 LH: sign-extend.
  - 010 LW: sign-extend.
  - 011 LD: valid only when XLEN=64.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend. LWU is valid only when XLEN=64.
  - LW, LD and LWU with XLEN=32: treated as a full word.
  - Reserved encodings return 0.
- Reset mid-access: a reset during REQ or WAIT returns the FSM to IDLE, and any later response is ignored. The memory must be reset by the same i_rst.
- The M register is never flushed. Flushes are applied upstream.

Optional Feature:
Macro RISCV_DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A captured access with off not a multiple of its size is misaligned.
  - For a misaligned access, no request is issued and the FSM goes directly to DONE, so there is no stall.
  - o_ctrl_reg_wr_enM is forced to 0 and o_misalignM=1, held for the life of that M entry.
- Undefined:
  - o_misalignM is tied to 0.
  - Misaligned accesses are issued with the truncated lanes described above.

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 load/store encodings;
  - result_src encodings;
  - FSM state encoding;
  - size-mask constants.
- One combinational sub-module, riscv_lsu_align, covers store lane/byte_sel generation and load extract/extend, parametrised by XLEN.

Test Plan:
1. LW at 0x100, ready=1, rsp one cycle later with 0xDEADBEEF -> o_stallM high 2 cycles, o_mem_readdataM=0xDEADBEEF, o_validM=1 on the following cycle.
2. LB at 0x103 with rdata 0x80112233 -> readdata 0xFFFFFF80. LBU at 0x103 -> 0x00000080. LHU at 0x102 -> 0x00008011.
3. SH at 0x102 with data 0x0000ABCD, ready low for 3 cycles -> byte_sel=4'b1100, wdata=0xABCD0000, addr=0x100, all held stable, stall 4 cycles, no response awaited.
4. Back-to-back ALU op, bubble (i_validE=0), ALU op -> no requests, o_stallM=0, o_validM pattern 1,0,1, o_alu_resultM delayed 1 cycle.
5. i_rst asserted during WAIT, then rsp_valid with 0x12345678 -> outputs 0, FSM IDLE, response ignored, readdata stays 0.
6. With RISCV_DMEM_MISALIGN_TRAP_EN defined, LW at 0x102 -> no req_valid, o_misalignM=1, o_ctrl_reg_wr_enM=0, o_stallM=0.
